wave_to_pipe_bram: RTL and testbench
====================================

# wave_to_pipe_bram

Dual-clock capture buffer that streams simulation waveforms to the host. Each enabled `sim_clk` cycle it writes one 32-bit IEEE-754 sample (e.g. `f_force_bic`, `f_bicepsfr_Ia`) into a BRAM FIFO. On `ti_clk` it drains the FIFO as 16-bit words into an `okBTPipeOut`, asserting `ep_ready` only when a whole block is available. It is the host-bound counterpart of `waveform_from_pipe_bram_2s`, which fills BRAM from an `okBTPipeIn` and pops on `sim_clk`.

## Interface
Parameters:
- `ADDR_W`, default 10: log2 of FIFO depth in 32-bit samples (1024 samples).
- `BLOCK_W16`, default 512: BTPipe block length in 16-bit words; must be even and ≤ 2·2^ADDR_W.

Ports:
- `push_clk`, in, 1: sample clock (`sim_clk`).
- `pipe_clk`, in, 1: host interface clock (`ti_clk`).
- `reset_global`, in, 1: reset, asynchronous, active-high.
- `push_en`, in, 1: capture `wave_in` on this `push_clk` edge.
- `wave_in`, in, 32: sample to record.
- `pipe_out_read`, in, 1: `ep_read` from `okBTPipeOut`.
- `pipe_out_data`, out, 16: `ep_datain`.
- `pipe_out_ready`, out, 1: `ep_ready`; high when at least one block is buffered.
- `overflow`, out, 1: sticky flag in the push domain; set when a sample is dropped.
- `underflow`, out, 1: sticky flag in the pipe domain; set on a read while empty.
- `fill_w16`, out, ADDR_W+2: pipe-domain occupancy in 16-bit words.

## Operation
- Storage: 2^ADDR_W × 32 simple dual-port BRAM. Write port on `push_clk`, read port on `pipe_clk`.
- Write side:
  - On `push_en` and not full: write `wave_in` at `wptr`, then `wptr` increments.
  - On `push_en` while full: the sample is discarded, `wptr` holds, and `overflow` is set.
- Pointers are ADDR_W+1 bits; the MSB distinguishes full from empty.
  - Full: `wptr_gray` equals synchronized `rptr_gray` with its two MSBs inverted.
  - Empty: `rptr == wptr_sync`.
- Read side has a half-word select `hsel`. Readout order per sample: low half `[15:0]` first, then `[31:16]`.
  - On `pipe_out_read` while not empty: output the selected half and toggle `hsel`.
  - `rptr` increments when `hsel` goes 1→0.
- On `pipe_out_read` while empty: `pipe_out_data` repeats its last value, pointers hold, and `underflow` is set.
- `fill_w16 = 2·(wptr_sync − rptr) − hsel`, computed modulo 2^(ADDR_W+1) before doubling.
- `pipe_out_ready = (fill_w16 ≥ BLOCK_W16)`, registered. It is sampled by the host only at block start; once a block starts it completes without gaps.
- Pointer wrap is natural binary rollover. Gray code keeps cross-domain compares safe across the wrap.
- A simultaneous push and read on the same address is safe: the write side cannot reach the read address unless full.

## Timing
- `pipe_out_data` is registered. The word for a read asserted at `pipe_clk` edge n is valid from edge n+1, matching `okBTPipeOut` one-cycle read latency.
- Back-to-back reads sustain one word per `pipe_clk`. A BRAM prefetch register holds the next sample.
- Write-to-visibility latency: 1 `push_clk` + 2 `pipe_clk` (gray synchronizer) + 1 `pipe_clk` (ready register).
- Read-to-free latency on the write side: 2 `push_clk`. Full is therefore conservative, never optimistic.
- Reset (`reset_global`, async assert, deassert synchronized separately in each domain):
  - `wptr`, `rptr`, `hsel`, `overflow`, `underflow` = 0.
  - `pipe_out_data` = 16'h0000, `pipe_out_ready` = 0, `fill_w16` = 0.
  - BRAM contents are not cleared.
- Reset mid-block: the FIFO empties immediately and `pipe_out_ready` drops. The host transfer is aborted, and any subsequent reads return 0 with `underflow` set.

## Structure
- Package `wave_pipe_pkg`:
  - Defaults `ADDR_W`, `BLOCK_W16`.
  - Functions `bin2gray` and `gray2bin`.
  - Half-select encoding `HS_LO = 0`, `HS_HI = 1`.
- Sub-module `gray_ptr_sync`: 2-flop synchronizer for an (ADDR_W+1)-bit gray bus, with async reset. Instantiated twice, once per direction.
- BRAM is inferred in-module. No vendor primitive is used.

## Test plan
- Basic block: push 256 samples 32'h0000_0000…32'h0000_00FF, then read 512 words. Expect `pipe_out_ready` high only after the 256th push. Data sequence is 0000,0000,0001,0000,…; final `fill_w16` = 0 and `pipe_out_ready` low.
- Threshold: push 255 samples. Expect `pipe_out_ready` to stay 0 and `fill_w16` = 510. The 256th push raises ready within ≤4 `pipe_clk`.
- Overflow: push 1030 samples with no reads. Expect `overflow` = 1 from the 1025th push, `fill_w16` = 2048, and a readout of exactly samples 0–1023.
- Wrap: run 3000 pushes at `sim_clk` = ti_clk/3 with the host draining blocks concurrently. Expect an ordered, gap-free stream and `overflow` = `underflow` = 0.
- Underflow: read 3 words from an empty FIFO. Expect `pipe_out_data` = 0000 and `underflow` = 1.
- Reset mid-block: assert `reset_global` after 100 words of a 512-word block. Expect all outputs at reset values within one cycle, and a fresh 256-sample block to stream correctly after release.

Source files
------------

// File: rtl/wave_pipe_pkg.sv
// Shared defaults, half-word select encoding and gray-code helpers for the
// waveform-to-host capture FIFO.
package wave_pipe_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_BLOCK_W16 = 512;
    localparam int SAMPLE_W      = 32;
    localparam int WORD_W        = 16;

    typedef enum logic {
        HS_LO = 1'b0,
        HS_HI = 1'b1
    } hsel_t;

    // Helpers work on a 32-bit container; callers zero-extend and truncate.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wave_to_pipe_bram_gray_ptr_sync.sv
// Two-flop synchronizer for a gray-coded FIFO pointer crossing clock domains.
module gray_ptr_sync #(
    parameter int W = 11
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_gray
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_gray;
            r_sync <= r_meta;
        end
    end

    assign o_gray = r_sync;

endmodule

// File: rtl/wave_to_pipe_bram.sv
// Dual-clock capture FIFO: 32-bit samples written on push_clk, drained as
// 16-bit words (low half first) into a block-throttled pipe on pipe_clk.
module wave_to_pipe_bram
    import wave_pipe_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BLOCK_W16 = DEF_BLOCK_W16
) (
    input  logic                push_clk,
    input  logic                pipe_clk,
    input  logic                reset_global,
    input  logic                push_en,
    input  logic [SAMPLE_W-1:0] wave_in,
    input  logic                pipe_out_read,
    output logic [WORD_W-1:0]   pipe_out_data,
    output logic                pipe_out_ready,
    output logic                overflow,
    output logic                underflow,
    output logic [ADDR_W+1:0]   fill_w16
);

    localparam int                PW        = ADDR_W + 1;
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W+1:0] BLOCK_THR = (ADDR_W+2)'(BLOCK_W16);

    // Per-domain reset: asserts asynchronously, releases on the local clock.
    logic [1:0] r_push_rst_sync;
    logic [1:0] r_pipe_rst_sync;
    logic       w_push_rst;
    logic       w_pipe_rst;

    always_ff @(posedge push_clk or posedge reset_global) begin
        if (reset_global) r_push_rst_sync <= 2'b11;
        else              r_push_rst_sync <= {r_push_rst_sync[0], 1'b0};
    end

    always_ff @(posedge pipe_clk or posedge reset_global) begin
        if (reset_global) r_pipe_rst_sync <= 2'b11;
        else              r_pipe_rst_sync <= {r_pipe_rst_sync[0], 1'b0};
    end

    assign w_push_rst = r_push_rst_sync[1];
    assign w_pipe_rst = r_pipe_rst_sync[1];

    logic [SAMPLE_W-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_wptr_gray;
    logic [PW-1:0] w_wptr_next;
    logic [PW-1:0] w_rptr_gray_sync;
    logic          w_full;
    logic          w_push_ok;
    logic          r_overflow;

    // Full compares against a delayed read pointer, so it can only be late to clear.
    assign w_full      = (r_wptr_gray == {~w_rptr_gray_sync[PW-1:PW-2], w_rptr_gray_sync[PW-3:0]});
    assign w_push_ok   = push_en && !w_full && !w_push_rst;
    assign w_wptr_next = r_wptr + PW'(1);

    always_ff @(posedge push_clk or posedge w_push_rst) begin
        if (w_push_rst) begin
            r_wptr      <= '0;
            r_wptr_gray <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr      <= w_wptr_next;
                r_wptr_gray <= PW'(bin2gray(32'(w_wptr_next)));
            end
            if (push_en && w_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge push_clk) begin
        if (w_push_ok) r_mem[r_wptr[ADDR_W-1:0]] <= wave_in;
    end

    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_rptr_gray;
    logic [PW-1:0] w_rptr_next;
    logic [PW-1:0] w_wptr_gray_sync;
    logic [PW-1:0] w_wptr_sync;
    logic [PW-1:0] w_diff;
    hsel_t         r_hsel;
    logic          w_empty;
    logic          w_rd_ok;
    logic          w_adv;
    logic [SAMPLE_W-1:0] r_rdata;
    logic [WORD_W-1:0]   r_dout;
    logic          r_ready;
    logic          r_underflow;

    assign w_wptr_sync = PW'(gray2bin(32'(w_wptr_gray_sync)));
    assign w_empty     = (r_rptr == w_wptr_sync);
    assign w_rd_ok     = pipe_out_read && !w_empty;
    assign w_adv       = w_rd_ok && (r_hsel == HS_HI);
    assign w_rptr_next = w_adv ? (r_rptr + PW'(1)) : r_rptr;
    assign w_diff      = w_wptr_sync - r_rptr;
    assign fill_w16    = {w_diff, 1'b0} - (ADDR_W+2)'(r_hsel == HS_HI);

    // Prefetch addressed by the next pointer keeps r_rdata == mem[r_rptr]
    // one cycle ahead, so back-to-back reads never stall.
    always_ff @(posedge pipe_clk) begin
        r_rdata <= r_mem[w_rptr_next[ADDR_W-1:0]];
    end

    always_ff @(posedge pipe_clk or posedge w_pipe_rst) begin
        if (w_pipe_rst) begin
            r_rptr      <= '0;
            r_rptr_gray <= '0;
            r_hsel      <= HS_LO;
            r_dout      <= '0;
            r_ready     <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_ready <= (fill_w16 >= BLOCK_THR);
            if (w_rd_ok) begin
                r_dout <= (r_hsel == HS_HI) ? r_rdata[SAMPLE_W-1:WORD_W] : r_rdata[WORD_W-1:0];
                r_hsel <= (r_hsel == HS_HI) ? HS_LO : HS_HI;
            end
            if (w_adv) begin
                r_rptr      <= w_rptr_next;
                r_rptr_gray <= PW'(bin2gray(32'(w_rptr_next)));
            end
            if (pipe_out_read && w_empty) r_underflow <= 1'b1;
        end
    end

    gray_ptr_sync #(.W(PW)) u_wptr_to_pipe (
        .i_clk  (pipe_clk),
        .i_rst  (w_pipe_rst),
        .i_gray (r_wptr_gray),
        .o_gray (w_wptr_gray_sync)
    );

    gray_ptr_sync #(.W(PW)) u_rptr_to_push (
        .i_clk  (push_clk),
        .i_rst  (w_push_rst),
        .i_gray (r_rptr_gray),
        .o_gray (w_rptr_gray_sync)
    );

    assign pipe_out_data  = r_dout;
    assign pipe_out_ready = r_ready;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule

// File: tb/tb_wave_to_pipe_bram.sv
// Directed bench for wave_to_pipe_bram with a word-level scoreboard queue.
module tb_wave_to_pipe_bram;

    localparam int ADDR_W    = 10;
    localparam int BLOCK_W16 = 512;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              push_clk      = 1'b0;
    logic              pipe_clk      = 1'b0;
    logic              reset_global  = 1'b1;
    logic              push_en       = 1'b0;
    logic [31:0]       wave_in       = '0;
    logic              pipe_out_read = 1'b0;
    logic [15:0]       pipe_out_data;
    logic              pipe_out_ready;
    logic              overflow;
    logic              underflow;
    logic [ADDR_W+1:0] fill_w16;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] sb[$];

    wave_to_pipe_bram #(.ADDR_W(ADDR_W), .BLOCK_W16(BLOCK_W16)) dut (
        .push_clk       (push_clk),
        .pipe_clk       (pipe_clk),
        .reset_global   (reset_global),
        .push_en        (push_en),
        .wave_in        (wave_in),
        .pipe_out_read  (pipe_out_read),
        .pipe_out_data  (pipe_out_data),
        .pipe_out_ready (pipe_out_ready),
        .overflow       (overflow),
        .underflow      (underflow),
        .fill_w16       (fill_w16)
    );

    // ti_clk period 10, sim_clk = ti_clk/3 with a phase offset
    always #5 pipe_clk = ~pipe_clk;
    initial begin
        #2;
        forever #15 push_clk = ~push_clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge push_clk);
            push_en = 1'b1;
            wave_in = base + 32'(i);
            if (sb.size() < 2 * DEPTH) begin
                sb.push_back(wave_in[15:0]);
                sb.push_back(wave_in[31:16]);
            end
            @(posedge push_clk);
        end
        @(negedge push_clk);
        push_en = 1'b0;
    endtask

    task automatic read_n(input int n, input string tag);
        logic [15:0] exp;
        for (int i = 0; i < n; i++) begin
            @(negedge pipe_clk);
            pipe_out_read = 1'b1;
            @(posedge pipe_clk);
            #1;
            exp = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
            chk(tag, 32'(pipe_out_data), 32'(exp));
        end
        @(negedge pipe_clk);
        pipe_out_read = 1'b0;
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int c;
        c = 0;
        while (!pipe_out_ready && c < budget) begin
            @(negedge pipe_clk);
            c++;
        end
        chk(tag, 32'(pipe_out_ready), 32'd1);
    endtask

    task automatic do_reset();
        push_en       = 1'b0;
        pipe_out_read = 1'b0;
        reset_global  = 1'b1;
        repeat (3) @(negedge pipe_clk);
        reset_global = 1'b0;
        sb.delete();
        repeat (4) @(negedge push_clk);
    endtask

    initial begin
        int c;

        // Reset values while reset is held
        repeat (3) @(negedge pipe_clk);
        chk("rst_data",  32'(pipe_out_data),  32'h0);
        chk("rst_ready", 32'(pipe_out_ready), 32'd0);
        chk("rst_fill",  32'(fill_w16),       32'd0);
        chk("rst_ovf",   32'(overflow),       32'd0);
        chk("rst_unf",   32'(underflow),      32'd0);
        reset_global = 1'b0;
        repeat (4) @(negedge push_clk);

        // Threshold then basic block
        push_n(255, 32'h0000_0000);
        repeat (8) @(negedge pipe_clk);
        chk("thr_ready_low", 32'(pipe_out_ready), 32'd0);
        chk("thr_fill",      32'(fill_w16),       32'd510);
        push_n(1, 32'h0000_00FF);
        wait_ready(4, "thr_ready_rise");
        read_n(512, "basic_data");
        repeat (4) @(negedge pipe_clk);
        chk("basic_fill_end",  32'(fill_w16),       32'd0);
        chk("basic_ready_end", 32'(pipe_out_ready), 32'd0);
        chk("basic_unf",       32'(underflow),      32'd0);
        chk("basic_ovf",       32'(overflow),       32'd0);

        // Underflow: data holds last word (high half of 0xFF = 0000)
        read_n(3, "unf_data");
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_fill", 32'(fill_w16),  32'd0);

        // Overflow
        do_reset();
        chk("ovf_rst_unf", 32'(underflow), 32'd0);
        push_n(1024, 32'hA500_0000);
        chk("ovf_before", 32'(overflow), 32'd0);
        push_n(1, 32'hA500_0400);
        chk("ovf_set", 32'(overflow), 32'd1);
        push_n(5, 32'hA500_0401);
        repeat (8) @(negedge pipe_clk);
        chk("ovf_fill",  32'(fill_w16),       32'd2048);
        chk("ovf_ready", 32'(pipe_out_ready), 32'd1);
        read_n(2048, "ovf_data");
        repeat (4) @(negedge pipe_clk);
        chk("ovf_fill_end", 32'(fill_w16),  32'd0);
        chk("ovf_unf",      32'(underflow), 32'd0);

        // Reset in the middle of a block
        do_reset();
        push_n(256, 32'h5A5A_0000);
        wait_ready(10, "mid_ready");
        read_n(100, "mid_data");
        reset_global = 1'b1;
        #1;
        chk("mid_rst_data",  32'(pipe_out_data),  32'h0);
        chk("mid_rst_ready", 32'(pipe_out_ready), 32'd0);
        chk("mid_rst_fill",  32'(fill_w16),       32'd0);
        chk("mid_rst_unf",   32'(underflow),      32'd0);
        chk("mid_rst_ovf",   32'(overflow),       32'd0);
        repeat (2) @(negedge pipe_clk);
        reset_global = 1'b0;
        sb.delete();
        repeat (4) @(negedge push_clk);
        read_n(1, "mid_post_data");
        chk("mid_post_unf", 32'(underflow), 32'd1);
        push_n(256, 32'h3C00_0000);
        wait_ready(10, "mid_fresh_ready");
        read_n(512, "mid_fresh_data");

        // Wrap with concurrent drain
        do_reset();
        fork
            push_n(3000, 32'h1234_0000);
            begin
                for (int b = 0; b < 11; b++) begin
                    repeat (2) @(negedge pipe_clk);
                    wait_ready(3000, "wrap_ready");
                    read_n(512, "wrap_data");
                end
            end
        join
        c = 0;
        while (fill_w16 != 12'd368 && c < 100) begin
            @(negedge pipe_clk);
            c++;
        end
        chk("wrap_tail_fill", 32'(fill_w16), 32'd368);
        read_n(368, "wrap_tail_data");
        repeat (4) @(negedge pipe_clk);
        chk("wrap_ovf",  32'(overflow),  32'd0);
        chk("wrap_unf",  32'(underflow), 32'd0);
        chk("wrap_fill", 32'(fill_w16),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
